// File: rtl/example_design_merge.sv
// Dual-lane receiver: buffers valid lane pairs in a DEPTH-pair FIFO and replays
// them serially (lane 0 then lane 1) under valid/ready, counting dropped pairs.
module example_design_merge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_data_0,
    input  logic [DATA_WIDTH-1:0]      i_data_1,
    input  logic                       i_clear,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_lane,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [CNT_WIDTH-1:0]       o_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]        PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    // Handshake: a word transfers on a rising edge where o_valid && i_ready;
    // once offered, o_data/o_lane/o_valid hold until that transfer happens.
    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_state_e;

    lane_state_e                 state_q;
    logic [PW-1:0]               wr_q, wr_d;
    logic [PW-1:0]               rd_q, rd_d;
    logic                        ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [2*DATA_WIDTH-1:0]     head;

    logic full, empty, push, drop, xfer, pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign push  = i_valid && !full;
    assign drop  = i_valid && full;
    assign xfer  = !empty && i_ready;
    assign pop   = xfer && (state_q == LANE1);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + PTR_ONE;
        if (pop)  rd_d = rd_q + PTR_ONE;
    end

    // Clear applies first, so a drop in the same cycle still registers as one.
    always_comb begin
        cnt_d = i_clear ? '0 : cnt_q;
        ovf_d = i_clear ? 1'b0 : ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {i_data_1, i_data_0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            case (state_q)
                LANE0:   if (xfer) state_q <= LANE1;
                LANE1:   if (xfer) state_q <= LANE0;
                default: state_q <= LANE0;
            endcase
        end
    end

    assign head         = mem_q[rd_q[AW-1:0]];
    assign o_valid      = !empty;
    assign o_lane       = state_q;
    assign o_data       = empty ? '0 :
                          (state_q == LANE1) ? head[2*DATA_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
    assign o_level      = wr_q - rd_q;
    assign o_overflow   = ovf_q;
    assign o_drop_count = cnt_q;

endmodule

// File: tb/tb_example_design_merge.sv
// Bench for example_design_merge: directed steps plus random traffic, checked
// every cycle against a queue-based model of the pair FIFO and serializer.
module tb_example_design_merge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_clear, i_ready;
    logic [DW-1:0] i_data_0, i_data_1;
    logic          o_valid, o_lane, o_overflow;
    logic [DW-1:0] o_data;
    logic [LW-1:0] o_level;
    logic [CW-1:0] o_drop_count;

    int total = 0;
    int bad   = 0;

    // model state
    logic [2*DW-1:0] m_q[$];
    bit              m_lane;
    int              m_cnt;
    bit              m_ovf;

    example_design_merge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_0(i_data_0), .i_data_1(i_data_1),
        .i_clear(i_clear), .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
        .o_lane(o_lane), .o_level(o_level), .o_overflow(o_overflow), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_lane = 0;
        m_cnt  = 0;
        m_ovf  = 0;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] exp_data;
        exp_data = '0;
        if (m_q.size() != 0) exp_data = m_lane ? m_q[0][2*DW-1:DW] : m_q[0][DW-1:0];
        chk("valid", {31'b0, o_valid}, {31'b0, m_q.size() != 0});
        chk("data",  {24'b0, o_data}, {24'b0, exp_data});
        chk("lane",  {31'b0, o_lane}, {31'b0, m_lane});
        chk("level", {29'b0, o_level}, m_q.size());
        chk("ovf",   {31'b0, o_overflow}, {31'b0, m_ovf});
        chk("count", {28'b0, o_drop_count}, m_cnt);
    endtask

    // One clock: check outputs on the falling edge, then apply the edge to the model.
    task automatic step();
        bit was_full, xfer;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        was_full = (m_q.size() == DEPTH);
        xfer     = (m_q.size() != 0) && i_ready;
        if (i_clear) begin
            m_cnt = 0;
            m_ovf = 0;
        end
        if (i_valid && was_full) begin
            m_ovf = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        if (xfer && m_lane) void'(m_q.pop_front());
        if (i_valid && !was_full) m_q.push_back({i_data_1, i_data_0});
        if (xfer) m_lane = !m_lane;
        #1;
    endtask

    task automatic set_in(input logic v, input logic r);
        i_valid  = v;
        i_ready  = r;
        i_data_0 = DW'($urandom);
        i_data_1 = DW'($urandom);
    endtask

    initial begin
        rst = 1'b1; i_valid = 0; i_clear = 0; i_ready = 0; i_data_0 = 0; i_data_1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_data",  {24'b0, o_data}, 0);
        chk("rst_lane",  {31'b0, o_lane}, 0);
        chk("rst_level", {29'b0, o_level}, 0);
        chk("rst_ovf",   {31'b0, o_overflow}, 0);
        chk("rst_count", {28'b0, o_drop_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single pair, consumer always ready
        i_valid = 1; i_ready = 1; i_data_0 = 8'hA5; i_data_1 = 8'h3C;
        step();
        i_valid = 0;
        chk("t1_valid", {31'b0, o_valid}, 1);
        chk("t1_w0",    {24'b0, o_data}, 32'hA5);
        chk("t1_l0",    {31'b0, o_lane}, 0);
        step();
        chk("t1_w1",    {24'b0, o_data}, 32'h3C);
        chk("t1_l1",    {31'b0, o_lane}, 1);
        step();
        chk("t1_empty", {31'b0, o_valid}, 0);
        chk("t1_level", {29'b0, o_level}, 0);

        // six pairs into a stalled FIFO: four stored, two dropped
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0);
            step();
        end
        set_in(0, 0);
        chk("t2_level", {29'b0, o_level}, 4);
        chk("t2_ovf",   {31'b0, o_overflow}, 1);
        chk("t2_count", {28'b0, o_drop_count}, 2);

        // drain with ready alternating 1,0
        for (int i = 0; i < 16; i++) begin
            set_in(0, (i % 2) == 0);
            step();
        end
        chk("t3_drained", {29'b0, o_level}, 0);

        // full FIFO, in lane 1 with pop and a new pair on the same edge
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0);
            step();
        end
        set_in(0, 1);
        step();
        chk("t4_lane1", {31'b0, o_lane}, 1);
        chk("t4_full",  {29'b0, o_level}, 4);
        set_in(1, 1);
        step();
        chk("t4_level", {29'b0, o_level}, 3);
        chk("t4_count", {28'b0, o_drop_count}, 3);
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1);
            step();
        end

        // saturation and clear ordering
        set_in(0, 0);
        i_clear = 1;
        step();
        i_clear = 0;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0);
            step();
        end
        chk("t5_sat", {28'b0, o_drop_count}, 15);
        set_in(1, 0);
        step();
        chk("t5_hold", {28'b0, o_drop_count}, 15);
        set_in(1, 0);
        i_clear = 1;
        step();
        chk("t5_clr_drop_cnt", {28'b0, o_drop_count}, 1);
        chk("t5_clr_drop_ovf", {31'b0, o_overflow}, 1);
        set_in(0, 0);
        step();
        i_clear = 0;
        chk("t5_clr_cnt", {28'b0, o_drop_count}, 0);
        chk("t5_clr_ovf", {31'b0, o_overflow}, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 2) != 0);
            i_clear = ($urandom_range(0, 24) == 0);
            step();
        end
        i_clear = 0;
        for (int i = 0; i < 12; i++) begin
            set_in(0, 1);
            step();
        end

        // asynchronous reset with three pairs stored, sitting in lane 1
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0);
            step();
        end
        set_in(0, 1);
        step();
        set_in(1, 0);
        chk("t6_pre_lane",  {31'b0, o_lane}, 1);
        chk("t6_pre_level", {29'b0, o_level}, 3);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", {31'b0, o_valid}, 0);
        chk("t6_level", {29'b0, o_level}, 0);
        chk("t6_lane",  {31'b0, o_lane}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_valid = 0;
        @(posedge clk);
        #1;
        i_valid = 1; i_ready = 0; i_data_0 = 8'h5A; i_data_1 = 8'hC3;
        step();
        i_valid = 0;
        chk("t6_new_valid", {31'b0, o_valid}, 1);
        chk("t6_new_data",  {24'b0, o_data}, 32'h5A);
        chk("t6_new_lane",  {31'b0, o_lane}, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/example_design_merge.md
# example_design_merge

Receiving end for the dual-lane generator's two parallel DATA_WIDTH streams. Captures each valid lane pair into a DEPTH-entry pair FIFO and replays the words serially on one output port: lane 0 first, then lane 1, under a valid/ready handshake. Counts and flags pairs dropped while the FIFO is full. Sits between the generator and any single-lane consumer or checker.

## Interface
- DATA_WIDTH, 8, width of each lane word and of o_data
- DEPTH, 4, FIFO capacity in lane pairs; power of two, ≥2
- CNT_WIDTH, 16, width of the drop counter
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  lane pair on i_data_0/i_data_1 is valid this cycle
- i_data_0  input  DATA_WIDTH  lane 0 word
- i_data_1  input  DATA_WIDTH  lane 1 word
- i_clear  input  1  synchronous clear of o_overflow and o_drop_count
- i_ready  input  1  downstream accepts o_data this cycle
- o_valid  output  1  o_data holds a word
- o_data  output  DATA_WIDTH  serialized word
- o_lane  output  1  lane of o_data: 0 = lane 0, 1 = lane 1
- o_level  output  $clog2(DEPTH)+1  pairs stored, 0..DEPTH
- o_overflow  output  1  sticky: at least one pair dropped
- o_drop_count  output  CNT_WIDTH  dropped pairs, saturating

## Operation
- Storage: DEPTH pairs. Read/write pointers are $clog2(DEPTH)+1 bits wide. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ. Pointers wrap naturally.
- Push: i_valid && !full writes {i_data_1, i_data_0} at the write pointer, then the write pointer increments.
- Drop: i_valid && full leaves the FIFO unchanged, sets o_overflow, and increments o_drop_count. The counter holds at all-ones.
- Full is evaluated at the start of the cycle. A pop completing in the same cycle does not make room: the pair is dropped.
- Output FSM, two states:
  - LANE0 (reset state): o_lane=0, o_data = head lane 0.
  - LANE1: o_lane=1, o_data = head lane 1.
- o_valid = !empty. When o_valid=0, o_data=0 and o_lane reflects the FSM state.
- Transfer occurs on o_valid && i_ready:
  - In LANE0: go to LANE1, no pop.
  - In LANE1: pop head (read pointer +1), go to LANE0.
- With i_ready low, o_data, o_lane and o_valid hold stable. A word is never withdrawn once offered.
- Push and pop in the same cycle (FIFO not full): both take effect, and o_level is unchanged.
- o_level = write pointer − read pointer (modulo pointer width).
- i_clear is evaluated first, then a drop in the same cycle is counted: the result is o_drop_count=1 and o_overflow=1. A clear with no drop gives 0/0.
- Reset asserted mid-operation discards all stored pairs and returns to LANE0 immediately (asynchronous). Data received during reset is ignored.

## Timing
- Reset values: o_valid=0, o_data=0, o_lane=0, o_level=0, o_overflow=0, o_drop_count=0. The FSM is in LANE0 and the pointers are 0.
- A pair pushed at edge N is offered (o_valid=1, lane 0) in the cycle after edge N: one-cycle latency. The output is a combinational read of registered storage.
- Lane 1 is offered in the cycle after the lane 0 transfer edge.
- Sustained throughput is one word per cycle, i.e. one pair per two cycles. An always-valid source therefore fills the FIFO and drops pairs, by design.
- o_level, o_overflow and o_drop_count update at the same edge as the push, pop or drop that changes them.
- Flags and counter are registered. The first edge after reset deassertion can push.

## Test plan
- Reset, then a single push of i_data_0=8'hA5, i_data_1=8'h3C with i_ready=1 → next cycle o_data=A5 with o_lane=0, following cycle o_data=3C with o_lane=1, then o_valid=0 and o_level=0.
- DEPTH=4, i_ready=0, six consecutive valid pairs → o_level=4, o_overflow=1, o_drop_count=2. Releasing i_ready drains exactly the first four pairs in order, 8 words, lane order 0,1.
- i_ready toggled 1,0,1,0 while draining → o_data and o_lane stable in every stalled cycle, and no word is skipped or duplicated.
- FIFO full, in LANE1 with i_ready=1 and i_valid=1 in the same cycle → the head is popped, the new pair is dropped, o_drop_count +1, and o_level goes from 4 to 3.
- o_drop_count preloaded to all-ones via repeated drops (CNT_WIDTH=4), one more drop → stays 15. Then i_clear together with a drop → count=1, overflow=1. Then i_clear alone → 0/0.
- rst pulsed with 3 pairs stored while in LANE1 → o_valid=0, o_level=0, o_lane=0 asynchronously. The next push is offered cleanly as lane 0.
